// File: rtl/al4s3b_wb_initiator_pkg.sv
// Shared definitions for the fabric Wishbone initiator.
// Holds the initiator state encoding and the Wishbone width constants and
// timeout read value. The fabric register responders use the same constants.
package al4s3b_wb_initiator_pkg;

  localparam int WB_ADR_WIDTH  = 17;
  localparam int WB_DAT_WIDTH  = 32;
  localparam int WB_BSTB_WIDTH = WB_DAT_WIDTH / 8;

  // Read data returned when the responder never acknowledges.
  localparam logic [31:0] WB_TIMEOUT_RD_VALUE = 32'hBADF_ABAC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_init_state_e;

endpackage

// File: rtl/al4s3b_wb_timeout_cntr.sv
// Saturating bus-cycle counter for the Wishbone initiator's ACK timeout.
// Ports:
//   clk_i     - clock
//   rst_n_i   - asynchronous active-low reset
//   clr_i     - synchronous clear, wins over en_i
//   en_i      - count one cycle
//   expired_o - counter holds LIMIT-1; the cycle being sampled is the last one allowed
// LIMIT = 0 disables expiry; the initiator then waits forever.
module al4s3b_wb_timeout_cntr #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // A zero LIMIT would give a zero-width counter, so keep at least one bit.
  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/al4s3b_wb_initiator.sv
// Wishbone initiator: turns single commands into Wishbone cycles and returns
// read data or a timeout error.
// Handshake rule for both cmd_* and rsp_*: a transfer happens on a rising
// WB_CLK edge where valid and ready are both high; valid-side payload stays
// stable while valid is high and ready is low.
// Ports:
//   WB_CLK, WB_RST_N          - clock, async active-low reset
//   cmd_valid_i/cmd_ready_o   - command handshake; cmd_we/adr/byte_stb/wdat payload
//   rsp_valid_o/rsp_ready_i   - response handshake; rsp_rdat/rsp_err payload
//   busy_o                    - transaction in BUS or RESP
//   dbg_state_o               - current FSM state
//   WBm_*                     - registered Wishbone initiator signals, DAT_i/ACK_i inputs
module al4s3b_wb_initiator
  import al4s3b_wb_initiator_pkg::*;
#(
  parameter int                    ADR_WIDTH        = WB_ADR_WIDTH,
  parameter int                    DAT_WIDTH        = WB_DAT_WIDTH,
  parameter int                    TIMEOUT_CYCLES   = 16,
  parameter logic [DAT_WIDTH-1:0]  TIMEOUT_RD_VALUE = WB_TIMEOUT_RD_VALUE
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST_N,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [ADR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DAT_WIDTH/8-1:0] cmd_byte_stb_i,
  input  logic [DAT_WIDTH-1:0]   cmd_wdat_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DAT_WIDTH-1:0]   rsp_rdat_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [1:0]             dbg_state_o,
  output logic [ADR_WIDTH-1:0]   WBm_ADR_o,
  output logic                   WBm_CYC_o,
  output logic                   WBm_STB_o,
  output logic                   WBm_WE_o,
  output logic                   WBm_RD_o,
  output logic [DAT_WIDTH/8-1:0] WBm_BYTE_STB_o,
  output logic [DAT_WIDTH-1:0]   WBm_DAT_o,
  input  logic [DAT_WIDTH-1:0]   WBm_DAT_i,
  input  logic                   WBm_ACK_i
);

  wb_init_state_e         state_q, state_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DAT_WIDTH/8-1:0] bstb_q, bstb_d;
  logic [DAT_WIDTH-1:0]   wdat_q, wdat_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic                   rd_q, rd_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DAT_WIDTH-1:0]   rsp_rdat_q, rsp_rdat_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   cnt_clr, cnt_en, cnt_expired;

  al4s3b_wb_timeout_cntr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_cntr (
    .clk_i    (WB_CLK),
    .rst_n_i  (WB_RST_N),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    bstb_d      = bstb_q;
    wdat_d      = wdat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    rd_d        = rd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdat_d  = rsp_rdat_q;
    rsp_err_d   = rsp_err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          bstb_d  = cmd_byte_stb_i;
          wdat_d  = cmd_wdat_i;
          we_d    = cmd_we_i;
          rd_d    = ~cmd_we_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK is checked first so an ACK on the expiring cycle still succeeds.
        if (WBm_ACK_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rd_d        = 1'b0;
          rsp_rdat_d  = we_q ? '0 : WBm_DAT_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_expired) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rd_d        = 1'b0;
          rsp_rdat_d  = TIMEOUT_RD_VALUE;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      bstb_q      <= '0;
      wdat_q      <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdat_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      bstb_q      <= bstb_d;
      wdat_q      <= wdat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdat_q  <= rsp_rdat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q == ST_BUS) || (state_q == ST_RESP);
  assign dbg_state_o    = state_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdat_o     = rsp_rdat_q;
  assign rsp_err_o      = rsp_err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_RD_o       = rd_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_DAT_o      = wdat_q;

endmodule
